fetch_pc_unit: RTL
==================

# fetch_pc_unit

Instruction-fetch front end for the five-stage MIPS core. It consumes the ID-stage branch redirect (`branch`, `branch_addr`) and owns the architectural fetch PC, including delay-slot semantics. It also drives the instruction-bus request/response handshake and hands one instruction at a time to ID. It sits between the instruction SRAM-like bus and the IF/ID boundary; the exception unit can flush it.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset.

Ports:
- `clk`  in  1  — single clock, all state on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `branch`  in  1  — ID redirect request for the instruction in ID.
- `branch_addr`  in  32  — redirect target.
- `exc_flush`  in  1  — exception/eret flush; highest priority.
- `exc_pc`  in  32  — flush target.
- `id_stall`  in  1  — ID cannot accept an instruction this cycle.
- `inst_req`  out  1  — bus request valid.
- `inst_addr`  out  32  — request address.
- `inst_addr_ok`  in  1  — address phase accepted.
- `inst_data_ok`  in  1  — read data valid.
- `inst_rdata`  in  32  — read data.
- `if_valid`  out  1  — `if_inst`/`if_pc` hold a valid instruction for ID.
- `if_pc`  out  32  — PC of the held instruction.
- `if_inst`  out  32  — held instruction word.
- `if_adel`  out  1  — fetch address error flag (see Configuration).

## Operation
- FSM states: REQ, WAIT, HOLD.
  - REQ: `inst_req`=1 with `inst_addr`=`pc`. On `inst_addr_ok`, go to WAIT.
  - WAIT: on `inst_data_ok`, capture `inst_rdata` into `if_inst`, capture `pc` into `if_pc`, go to HOLD.
  - HOLD: `if_valid`=1. Handover occurs when `!id_stall`. On handover, `pc` ← next PC and the FSM returns to REQ.
- Next PC = `redir_pc` if `redir_vld`, else `pc`+4 (mod 2^32; wraps 32'hFFFF_FFFC → 0).
- Redirect capture: `branch & !id_stall` sets `redir_vld` and loads `redir_pc` ← `branch_addr`. The instruction currently in IF is the delay slot and is always delivered. `redir_vld` clears on the handover that consumes it.
- `branch` is ignored while `id_stall`=1; ID re-presents it.
- `exc_flush` (any state):
  - `pc` ← `exc_pc`; `redir_vld` cleared; `if_valid` dropped; FSM → REQ.
  - If flushed in WAIT, or in REQ in the same cycle as `inst_addr_ok`, set `drop`. The next `inst_data_ok` is then discarded and clears `drop`.
  - While `drop`=1, REQ must not assert `inst_req` (one outstanding transaction maximum).
- Flush and branch in the same cycle: the flush wins and the branch is discarded.
- Reset values: `pc`=`RESET_PC`, state=REQ, `redir_vld`=0, `drop`=0, `if_valid`=0, `if_pc`=0, `if_inst`=0, `if_adel`=0.
- Reset does not assert `inst_req` during the reset cycle itself.

## Timing
- `inst_req`/`inst_addr` are held stable from assertion until `inst_addr_ok`. They are never withdrawn except by `exc_flush`.
- `inst_data_ok` is accepted no earlier than the cycle after `inst_addr_ok`.
- Best case: `inst_req` at C0 with `addr_ok` at C0, `data_ok` at C1, `if_valid` at C2, handover at C2, next `inst_req` at C3. That is 3 cycles per instruction.
- `if_valid`/`if_pc`/`if_inst` are registered outputs. `inst_req` is a decode of the registered state and `drop` only, with no combinational path from `branch`.
- Stalled ID: the HOLD outputs remain unchanged for any number of cycles.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In REQ with `pc[1:0]`≠0, no bus request is issued.
  - The FSM goes directly to HOLD with `if_adel`=1, `if_inst`=32'h0, `if_pc`=`pc`.
- Undefined: no alignment check. `if_adel` is tied 0, and `inst_addr` = {`pc[31:2]`,2'b00}.

## Structure
- The shared package holds:
  - the FSM state enum (`fetch_state_t`),
  - the `RESET_PC` default constant,
  - the `exc_flush` priority encoding.
- Address/data widths reuse the existing `W_ADDR`/`W_DATA` definitions.
- One sub-module, `fetch_redirect_buf`, holds `redir_vld`/`redir_pc`/`drop` and the next-PC mux. The FSM and output registers stay in `fetch_pc_unit`.

## Test plan
- Reset release, bus answers `addr_ok` immediately and `data_ok` 1 cycle later -> first request `inst_addr`=32'hBFC0_0000, `if_valid` 2 cycles after request, `if_pc`=32'hBFC0_0000; second request at 32'hBFC0_0004.
- `branch`=1, `branch_addr`=32'hBFC0_0100 while IF fetches 32'hBFC0_0008 -> instruction at 32'hBFC0_0008 delivered, then next request at 32'hBFC0_0100.
- `id_stall` held 5 cycles in HOLD with `branch` asserted throughout -> outputs stable, no redirect captured until the `id_stall`=0 cycle.
- `exc_flush`, `exc_pc`=32'hBFC0_0380, in WAIT -> `if_valid` 0; stale `data_ok` dropped; no `inst_req` until it arrives; then request at 32'hBFC0_0380.
- `exc_flush` and `branch` in the same cycle -> next fetch at `exc_pc`, branch target never requested.
- With `FETCH_ALIGN_CHECK_EN`, `branch_addr`=32'hBFC0_0102 -> delay slot delivered, then `if_valid`=1, `if_adel`=1, `if_pc`=32'hBFC0_0102, and no `inst_req` for that PC.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Shared definitions for the instruction-fetch front end:
//   W_ADDR / W_DATA    : bus address and data widths
//   RESET_PC_DEFAULT   : default first fetch address after reset
//   fetch_state_t      : fetch FSM states (REQ, WAIT, HOLD)
//   pc_event_t         : PC update source, ordered by priority
//   pc_event()         : priority encoder; exc_flush beats handover
// ----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

    localparam int unsigned W_ADDR = 32;
    localparam int unsigned W_DATA = 32;

    localparam logic [W_ADDR-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_EV_NONE     = 2'd0,
        PC_EV_HANDOVER = 2'd1,
        PC_EV_FLUSH    = 2'd2
    } pc_event_t;

    // A flush overrides whatever else the fetch unit would do this cycle.
    function automatic pc_event_t pc_event(input logic flush, input logic handover);
        pc_event_t ev;
        ev = PC_EV_NONE;
        if (flush) begin
            ev = PC_EV_FLUSH;
        end else if (handover) begin
            ev = PC_EV_HANDOVER;
        end
        return ev;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_redirect_buf.sv
// ----------------------------------------------------------------------------
// fetch_redirect_buf
// Holds the pending branch redirect (redir_vld/redir_pc), the drop flag for a
// stale in-flight bus read, and selects the next fetch PC.
//   clk, rst        : clock, asynchronous active-high reset
//   branch          : ID redirect request
//   branch_addr     : redirect target
//   id_stall        : ID not accepting; branch is ignored while set
//   exc_flush       : flush; clears the pending redirect
//   handover        : HOLD instruction accepted by ID this cycle
//   drop_set        : a flush abandoned an outstanding bus read
//   inst_data_ok    : bus read data valid (retires the stale read)
//   pc              : current fetch PC
//   next_pc         : PC to load on handover
//   drop            : a stale read is still outstanding
// ----------------------------------------------------------------------------
module fetch_redirect_buf
    import fetch_pc_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic [W_ADDR-1:0] branch_addr,
    input  logic              id_stall,
    input  logic              exc_flush,
    input  logic              handover,
    input  logic              drop_set,
    input  logic              inst_data_ok,
    input  logic [W_ADDR-1:0] pc,
    output logic [W_ADDR-1:0] next_pc,
    output logic              drop
);

    logic              redir_vld_q, redir_vld_d;
    logic [W_ADDR-1:0] redir_pc_q,  redir_pc_d;
    logic              drop_q,      drop_d;
    logic              br_take;

    assign br_take = branch & ~id_stall & ~exc_flush;
    assign drop    = drop_q;

    // A branch accepted in the same cycle as the handover is forwarded
    // directly, so the delay slot leaves and the target is fetched next.
    always_comb begin
        if (br_take) begin
            next_pc = branch_addr;
        end else if (redir_vld_q) begin
            next_pc = redir_pc_q;
        end else begin
            next_pc = pc + 32'd4;
        end
    end

    always_comb begin
        redir_vld_d = redir_vld_q;
        redir_pc_d  = redir_pc_q;
        drop_d      = drop_q;
        if (br_take) begin
            redir_vld_d = 1'b1;
            redir_pc_d  = branch_addr;
        end
        if (handover || exc_flush) begin
            redir_vld_d = 1'b0;
        end
        if (drop_q && inst_data_ok) begin
            drop_d = 1'b0;
        end
        if (drop_set) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit
// Instruction-fetch front end: owns the fetch PC (with delay-slot redirect),
// runs the instruction-bus request/response handshake and presents one
// instruction at a time to ID.
//   Parameter RESET_PC : first fetch address after reset
//   clk, rst           : clock, asynchronous active-high reset
//   branch/branch_addr : ID redirect request and target
//   exc_flush/exc_pc   : exception flush (highest priority) and target
//   id_stall           : ID cannot accept an instruction
//   inst_req/inst_addr : bus address phase
//   inst_addr_ok       : address phase accepted
//   inst_data_ok/inst_rdata : read data phase
//   if_valid/if_pc/if_inst  : held instruction for ID
//   if_adel            : fetch address error
// Build option: FETCH_ALIGN_CHECK_EN enables the PC alignment check; when it
// is undefined if_adel stays 0 and the address is forced word-aligned.
// ----------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [W_ADDR-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic [W_ADDR-1:0] branch_addr,
    input  logic              exc_flush,
    input  logic [W_ADDR-1:0] exc_pc,
    input  logic              id_stall,
    output logic              inst_req,
    output logic [W_ADDR-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [W_DATA-1:0] inst_rdata,
    output logic              if_valid,
    output logic [W_ADDR-1:0] if_pc,
    output logic [W_DATA-1:0] if_inst,
    output logic              if_adel
);

    fetch_state_t      state_q;
    logic [W_ADDR-1:0] pc_q;
    logic              if_valid_q;
    logic [W_ADDR-1:0] if_pc_q;
    logic [W_DATA-1:0] if_inst_q;
    logic              if_adel_q;

    logic [W_ADDR-1:0] next_pc;
    logic              drop;
    logic              addr_err;
    logic              handover;
    logic              drop_set;
    pc_event_t         ev;

`ifdef FETCH_ALIGN_CHECK_EN
    assign addr_err  = (pc_q[1:0] != 2'b00);
    assign inst_addr = pc_q;
`else
    assign addr_err  = 1'b0;
    assign inst_addr = {pc_q[W_ADDR-1:2], 2'b00};
`endif

    // Held low during reset and while a stale read is still outstanding.
    assign inst_req = ~rst & (state_q == FS_REQ) & ~drop & ~addr_err;

    assign handover = (state_q == FS_HOLD) & ~id_stall & ~exc_flush;

    // A flush with a read in flight leaves one data_ok to discard. A flush
    // coinciding with that data_ok retires the read, so nothing is owed.
    assign drop_set = exc_flush &
                      (((state_q == FS_WAIT) & ~inst_data_ok) |
                       (inst_req & inst_addr_ok));

    assign ev = pc_event(exc_flush, handover);

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_adel  = if_adel_q;

    fetch_redirect_buf u_redirect_buf (
        .clk          (clk),
        .rst          (rst),
        .branch       (branch),
        .branch_addr  (branch_addr),
        .id_stall     (id_stall),
        .exc_flush    (exc_flush),
        .handover     (handover),
        .drop_set     (drop_set),
        .inst_data_ok (inst_data_ok),
        .pc           (pc_q),
        .next_pc      (next_pc),
        .drop         (drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_REQ;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_adel_q  <= 1'b0;
        end else begin
            unique case (ev)
                PC_EV_FLUSH: begin
                    pc_q       <= exc_pc;
                    state_q    <= FS_REQ;
                    if_valid_q <= 1'b0;
                    if_adel_q  <= 1'b0;
                end
                PC_EV_HANDOVER: begin
                    pc_q       <= next_pc;
                    state_q    <= FS_REQ;
                    if_valid_q <= 1'b0;
                    if_adel_q  <= 1'b0;
                end
                default: begin
                    unique case (state_q)
                        FS_REQ: begin
                            if (addr_err) begin
                                state_q    <= FS_HOLD;
                                if_valid_q <= 1'b1;
                                if_adel_q  <= 1'b1;
                                if_pc_q    <= pc_q;
                                if_inst_q  <= '0;
                            end else if (inst_req && inst_addr_ok) begin
                                state_q <= FS_WAIT;
                            end
                        end
                        FS_WAIT: begin
                            if (inst_data_ok) begin
                                state_q    <= FS_HOLD;
                                if_valid_q <= 1'b1;
                                if_pc_q    <= pc_q;
                                if_inst_q  <= inst_rdata;
                            end
                        end
                        FS_HOLD: begin
                            state_q <= FS_HOLD;
                        end
                        default: begin
                            state_q <= FS_REQ;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
